// File: rtl/capture_unit.sv
// Acquisition/dump controller for the oscilloscope's circular sample RAM.
// Captures decimated samples around a qualified trigger, then streams the buffer oldest-first.
module capture_unit #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rclk,
    output logic [AW-1:0] addr,
    output logic          en,
    output logic          we,
    input  logic [3:0]    dec_pwr,
    input  logic [1:0]    trig_type,
    input  logic          trigger,
    input  logic [AW-1:0] trig_pos,
    output logic          armed,
    input  logic          capture_done,
    output logic          set_capture_done,
    input  logic          start_dump,
    input  logic          dump_sent,
    output logic          send_dump,
    output logic          dump_finished
);
    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        POST,
        DUMP_RD,
        DUMP_SEND,
        DUMP_WAIT
    } state_t;

    localparam logic [AW:0]   FULL  = DEPTH[AW:0];
    localparam logic [AW-1:0] ONE_A = AW'(1);
    localparam logic [AW:0]   ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    state_t state;
    state_t state_next;

    logic          rclk_q;
    logic          trig_q;
    logic [15:0]   dec_cnt;
    logic [15:0]   dec_max;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [AW:0]   send_cnt;
    logic          wait_skip;

    logic rclk_rise;
    logic strobe;
    logic trig_hit;
    logic trig_qual;
    logic write_now;
    logic idle_free;
    logic start_capture;
    logic start_rd;
    logic post_done;
    logic wait_done;

    always_comb begin
        rclk_rise = rclk & ~rclk_q;
        dec_max   = (16'd1 << dec_pwr) - 16'd1;
        strobe    = rclk_rise && (dec_cnt == dec_max);

        case (trig_type)
            2'b00:   trig_hit = 1'b1;
            2'b01:   trig_hit = trigger & ~trig_q;
            2'b10:   trig_hit = ~trigger & trig_q;
            default: trig_hit = 1'b0;
        endcase

        trig_qual = (state == SAMPLE) && armed && trig_hit;
        // Once the post counter is exhausted no further sample may land in RAM.
        write_now = strobe && ((state == SAMPLE) || ((state == POST) && (post_cnt != '0)));

        count_next = count;
        if (write_now && (state == SAMPLE) && (count != FULL))
            count_next = count + ONE_C;

        // The external done flag only rises one cycle after our pulse, so IDLE waits it out.
        idle_free     = (state == IDLE) && !set_capture_done;
        start_capture = idle_free && !capture_done;
        start_rd      = idle_free && capture_done && start_dump;
        post_done     = (state == POST) && (post_cnt == '0);
        wait_done     = (state == DUMP_WAIT) && !wait_skip && dump_sent;

        state_next = state;
        case (state)
            IDLE: begin
                if (start_capture)
                    state_next = SAMPLE;
                else if (start_rd)
                    state_next = DUMP_RD;
            end
            SAMPLE: begin
                if (trig_qual)
                    state_next = POST;
            end
            POST: begin
                if (post_done)
                    state_next = IDLE;
            end
            DUMP_RD: state_next = DUMP_SEND;
            DUMP_SEND: begin
                if (dump_sent)
                    state_next = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (wait_done)
                    state_next = (send_cnt == FULL) ? IDLE : DUMP_RD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rclk_q           <= 1'b0;
            trig_q           <= 1'b0;
            dec_cnt          <= '0;
            wr_ptr           <= '0;
            post_cnt         <= '0;
            last_addr        <= LAST;
            rd_ptr           <= '0;
            count            <= '0;
            send_cnt         <= '0;
            wait_skip        <= 1'b0;
            addr             <= '0;
            en               <= 1'b0;
            we               <= 1'b0;
            armed            <= 1'b0;
            set_capture_done <= 1'b0;
            send_dump        <= 1'b0;
            dump_finished    <= 1'b0;
        end else begin
            rclk_q           <= rclk;
            trig_q           <= trigger;
            en               <= 1'b0;
            we               <= 1'b0;
            set_capture_done <= 1'b0;
            send_dump        <= 1'b0;
            dump_finished    <= 1'b0;

            if (strobe)
                dec_cnt <= '0;
            else if (rclk_rise)
                dec_cnt <= dec_cnt + 16'd1;

            if (write_now) begin
                addr   <= wr_ptr;
                en     <= 1'b1;
                we     <= 1'b1;
                wr_ptr <= wr_ptr + ONE_A;
            end

            case (state)
                IDLE: begin
                    armed <= 1'b0;
                    if (start_capture) begin
                        wr_ptr  <= '0;
                        count   <= '0;
                        dec_cnt <= '0;
                    end else if (start_rd) begin
                        rd_ptr   <= last_addr + ONE_A;
                        send_cnt <= '0;
                    end
                end
                SAMPLE: begin
                    count <= count_next;
                    armed <= (count_next >= (FULL - {1'b0, trig_pos}));
                    if (trig_qual)
                        post_cnt <= trig_pos;
                end
                POST: begin
                    if (post_done) begin
                        last_addr        <= wr_ptr - ONE_A;
                        set_capture_done <= 1'b1;
                        armed            <= 1'b0;
                    end else if (write_now) begin
                        post_cnt <= post_cnt - ONE_A;
                    end
                end
                DUMP_RD: begin
                    armed <= 1'b0;
                    addr  <= rd_ptr;
                    en    <= 1'b1;
                end
                DUMP_SEND: begin
                    armed <= 1'b0;
                    if (dump_sent) begin
                        send_dump <= 1'b1;
                        send_cnt  <= send_cnt + ONE_C;
                        wait_skip <= 1'b1;
                    end
                end
                DUMP_WAIT: begin
                    armed <= 1'b0;
                    // The transmitter still shows ready in the pulse cycle; skip that stale level.
                    if (wait_skip)
                        wait_skip <= 1'b0;
                    else if (dump_sent) begin
                        if (send_cnt == FULL)
                            dump_finished <= 1'b1;
                        else
                            rd_ptr <= rd_ptr + ONE_A;
                    end
                end
                default: armed <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_unit.sv
// Directed testbench for capture_unit: capture with held/edge/never/auto triggers,
// full dump through a slow transmitter, and reset during a dump.
module tb_capture_unit;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rclk = 1'b0;
    logic [AW-1:0] addr;
    logic          en;
    logic          we;
    logic [3:0]    dec_pwr = 4'd2;
    logic [1:0]    trig_type = 2'b01;
    logic          trigger = 1'b1;
    logic [AW-1:0] trig_pos = 9'd100;
    logic          armed;
    logic          capture_done = 1'b0;
    logic          set_capture_done;
    logic          start_dump = 1'b0;
    logic          dump_sent = 1'b1;
    logic          send_dump;
    logic          dump_finished;
    logic          clr_done = 1'b0;
    int            busy = 0;
    int            tests = 0;
    int            fails = 0;

    capture_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .rclk             (rclk),
        .addr             (addr),
        .en               (en),
        .we               (we),
        .dec_pwr          (dec_pwr),
        .trig_type        (trig_type),
        .trigger          (trigger),
        .trig_pos         (trig_pos),
        .armed            (armed),
        .capture_done     (capture_done),
        .set_capture_done (set_capture_done),
        .start_dump       (start_dump),
        .dump_sent        (dump_sent),
        .send_dump        (send_dump),
        .dump_finished    (dump_finished)
    );

    always #5 clk = ~clk;
    always #10 rclk = ~rclk;

    // External done flag: set by the DUT pulse, cleared on request by the bench.
    always @(posedge clk) begin
        if (clr_done)
            capture_done <= 1'b0;
        else if (set_capture_done)
            capture_done <= 1'b1;
    end

    // Transmitter: drops ready the cycle after a send pulse and stays busy for 15 cycles.
    always @(posedge clk) begin
        if (send_dump) begin
            dump_sent <= 1'b0;
            busy      <= 15;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1)
                dump_sent <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cyc, writes, last_en, arm_at, scd_cnt, bad_addr, bad_we, bad_gap;
        int post_writes, last_wr, sends, rd_en, fin_cnt, fin_at, bad_send, extra;
        int first_send, last_send, en_cnt, send_cnt, armed_drop;
        bit done;

        cyc = 0; writes = 0; last_en = 0; arm_at = 0; scd_cnt = 0;
        bad_addr = 0; bad_we = 0; bad_gap = 0; post_writes = 0; last_wr = -1;

        // Reset: every output must be 0
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({addr, en, we, armed, set_capture_done, send_dump, dump_finished}), 0);
        @(negedge clk);
        check("reset_outputs_hold", 32'({addr, en, we, armed, set_capture_done, send_dump, dump_finished}), 0);

        // Capture with trigger held high: arms after 412 writes, never triggers
        rst = 1'b0;
        while (writes < 452 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (en) begin
                if (we !== 1'b1) bad_we++;
                if (addr !== AW'(writes % DEPTH)) bad_addr++;
                if (writes > 0 && (cyc - last_en) != 8) bad_gap++;
                last_en = cyc;
                writes++;
            end
            if (armed === 1'b1 && arm_at == 0) arm_at = writes;
            if (set_capture_done) scd_cnt++;
        end
        check("pre_writes_reached", writes, 452);
        check("armed_at_write", arm_at, 412);
        check("pre_addr_sequence_errors", bad_addr, 0);
        check("pre_we_errors", bad_we, 0);
        check("pre_write_gap_errors", bad_gap, 0);
        check("held_trigger_ignored", scd_cnt, 0);
        check("armed_while_waiting", armed, 1);

        // Trigger falls then rises: exactly 100 further writes, then one done pulse
        trigger = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        trigger = 1'b1;
        done = 1'b0;
        extra = 0;
        while (!done && extra < 1500) begin
            @(negedge clk);
            cyc++;
            extra++;
            if (en) begin
                if (we !== 1'b1) bad_we++;
                if (addr !== AW'(writes % DEPTH)) bad_addr++;
                if ((cyc - last_en) != 8) bad_gap++;
                last_en = cyc;
                last_wr = int'(addr);
                writes++;
                post_writes++;
            end
            if (set_capture_done) begin
                scd_cnt++;
                done = 1'b1;
            end
        end
        check("post_trigger_writes", post_writes, 100);
        check("total_writes", writes, 552);
        check("last_written_addr_wrapped", last_wr, 39);
        check("post_addr_sequence_errors", bad_addr, 0);
        check("post_write_gap_errors", bad_gap, 0);
        check("done_pulse_seen", scd_cnt, 1);

        en_cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (en) en_cnt++;
            if (set_capture_done) scd_cnt++;
        end
        check("no_writes_while_done", en_cnt, 0);
        check("single_done_pulse", scd_cnt, 1);
        check("armed_cleared_after_post", armed, 0);
        check("capture_done_flag", capture_done, 1);

        // Dump: 512 sends from addr 40 round to 39, then one finished pulse
        sends = 0; rd_en = 0; fin_cnt = 0; fin_at = -1; bad_send = 0; bad_we = 0;
        first_send = -1; last_send = -1; extra = 0;
        start_dump = 1'b1;
        while (fin_cnt == 0 && extra < 15000) begin
            @(negedge clk);
            start_dump = 1'b0;
            extra++;
            if (we) bad_we++;
            if (en) rd_en++;
            if (send_dump) begin
                if (addr !== AW'((40 + sends) % DEPTH)) bad_send++;
                if (sends == 0) first_send = int'(addr);
                last_send = int'(addr);
                sends++;
            end
            if (dump_finished) begin
                fin_cnt++;
                fin_at = sends;
            end
        end
        send_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (send_dump) send_cnt++;
            if (dump_finished) fin_cnt++;
        end
        check("dump_send_count", sends, 512);
        check("dump_read_enables", rd_en, 512);
        check("dump_first_addr", first_send, 40);
        check("dump_last_addr", last_send, 39);
        check("dump_addr_errors", bad_send, 0);
        check("dump_we_zero", bad_we, 0);
        check("dump_finished_once", fin_cnt, 1);
        check("dump_finished_after_last", fin_at, 512);
        check("no_send_after_finish", send_cnt, 0);

        // Never-trigger mode arms but does not complete; auto mode then completes
        trig_type = 2'b11;
        dec_pwr = 4'd0;
        trig_pos = 9'd10;
        clr_done = 1'b1;
        @(negedge clk);
        clr_done = 1'b0;
        writes = 0; arm_at = 0; extra = 0;
        while (arm_at == 0 && extra < 3000) begin
            @(negedge clk);
            extra++;
            if (en) writes++;
            if (armed === 1'b1) arm_at = writes;
        end
        check("never_mode_arm_at", arm_at, 502);
        scd_cnt = 0; armed_drop = 0;
        repeat (300) begin
            @(negedge clk);
            if (set_capture_done) scd_cnt++;
            if (armed !== 1'b1) armed_drop++;
        end
        check("never_mode_no_done", scd_cnt, 0);
        check("never_mode_stays_armed", armed_drop, 0);

        extra = 0;
        do begin
            @(negedge clk);
            extra++;
        end while (!en && extra < 20);
        trig_type = 2'b00;
        post_writes = 0; done = 1'b0; extra = 0;
        while (!done && extra < 200) begin
            @(negedge clk);
            extra++;
            if (en) post_writes++;
            if (set_capture_done) begin
                scd_cnt++;
                done = 1'b1;
            end
        end
        check("auto_mode_post_writes", post_writes, 10);
        check("auto_mode_done", scd_cnt, 1);

        // Reset in the middle of a dump
        repeat (3) @(negedge clk);
        sends = 0; extra = 0;
        start_dump = 1'b1;
        while (sends < 5 && extra < 300) begin
            @(negedge clk);
            start_dump = 1'b0;
            extra++;
            if (send_dump) sends++;
        end
        check("mid_dump_sends", sends, 5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_dump_reset_outputs", 32'({addr, en, we, armed, set_capture_done, send_dump, dump_finished}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_cnt = 0; fin_cnt = 0; en_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (send_dump) send_cnt++;
            if (dump_finished) fin_cnt++;
            if (en) en_cnt++;
        end
        check("no_send_after_reset", send_cnt, 0);
        check("no_finish_after_reset", fin_cnt, 0);
        check("idle_after_reset", en_cnt, 0);

        // A fresh dump from IDLE starts at last_addr(reset)+1 = 0
        first_send = -1; extra = 0;
        start_dump = 1'b1;
        while (first_send < 0 && extra < 300) begin
            @(negedge clk);
            start_dump = 1'b0;
            extra++;
            if (send_dump) first_send = int'(addr);
        end
        check("redump_first_addr", first_send, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
